// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexes four BCD digit fields onto a 4-digit active-low
// common-anode seven-segment display. The digits are snapshotted once per
// scan frame so that one frame never mixes old and new values. The digit pair
// that is being adjusted blinks, and the decimal point acts as the colon.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] counter3,
    input  logic [3:0] counter2,
    input  logic [2:0] counter1,
    input  logic [3:0] counter0,
    input  logic       isAdj,
    input  logic [1:0] select,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Segment pattern for one digit, active-low g..a; codes above 9 are blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic [1:0]    idx;
    logic          phase;
    logic          active;
    logic [2:0]    s3;
    logic [3:0]    s2;
    logic [2:0]    s1;
    logic [3:0]    s0;

    logic          tick;
    logic          bwrap;
    logic          frame_start;
    logic [1:0]    idx_n;
    logic          phase_n;
    logic          active_n;
    logic [2:0]    s3_n;
    logic [3:0]    s2_n;
    logic [2:0]    s1_n;
    logic [3:0]    s0_n;
    logic [3:0]    digit;
    logic          blank;

    assign tick        = (rcnt == RMAX);
    assign bwrap       = (bcnt == BMAX);
    assign frame_start = tick && (idx == 2'd3);

    // Slot refresh counter: one tick per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt <= '0;
        else        rcnt <= tick ? '0 : rcnt + 1'b1;
    end

    // Blink counter and phase free-run independently of adjust mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt  <= bwrap ? '0 : bcnt + 1'b1;
            phase <= phase_n;
        end
    end

    // Next-cycle view of scan state; outputs are computed from these so the
    // registered outputs line up with the edge where idx/snapshot/phase move.
    always_comb begin
        idx_n    = tick ? idx + 2'd1 : idx;
        phase_n  = phase ^ bwrap;
        active_n = active | tick;
        s3_n     = frame_start ? counter3 : s3;
        s2_n     = frame_start ? counter2 : s2;
        s1_n     = frame_start ? counter1 : s1;
        s0_n     = frame_start ? counter0 : s0;
    end

    // Scan index, first-tick flag and frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 2'd3;
            active <= 1'b0;
            s3     <= '0;
            s2     <= '0;
            s1     <= '0;
            s0     <= '0;
        end else begin
            idx    <= idx_n;
            active <= active_n;
            s3     <= s3_n;
            s2     <= s2_n;
            s1     <= s1_n;
            s0     <= s0_n;
        end
    end

    // Digit for the upcoming slot and whether adjust blinking hides it.
    always_comb begin
        digit = 4'd0;
        case (idx_n)
            2'd0: digit = s0_n;
            2'd1: digit = {1'b0, s1_n};
            2'd2: digit = s2_n;
            2'd3: digit = {1'b0, s3_n};
            default: digit = 4'd0;
        endcase
        blank = isAdj && phase_n &&
                (((select == 2'b01) && (idx_n >= 2'd2)) ||
                 ((select == 2'b10) && (idx_n <= 2'd1)));
    end

    // Registered display outputs; dark until the first slot tick after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (!active_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? AN_OFF : ~(4'b0001 << idx_n);
            seg <= blank ? SEG_OFF : decode(digit);
            dp  <= (idx_n != 2'd2);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: random and directed stimulus against a cycle-indexed
// reference model; expectations are queued per edge and checked by a monitor.
module tb_seven_seg_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] c3 = '0;
    logic [3:0] c2 = '0;
    logic [2:0] c1 = '0;
    logic [3:0] c0 = '0;
    logic       adj = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    seven_seg_scan #(.REFRESH_DIV(4), .BLINK_DIV(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .counter3(c3), .counter2(c2), .counter1(c1), .counter0(c0),
        .isAdj(adj), .select(sel),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int t = 0;

    // Input history indexed by edge number since reset release.
    logic [3:0] hd [4][1024];
    logic       ha [1024];
    logic [1:0] hs [1024];

    logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                             7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Expected outputs after edge tt: slot k starts at edge 4k, shows digit
    // (k-1) mod 4 taken from the inputs seen at that frame's first edge.
    function automatic exp_t model(input int tt);
        exp_t e;
        int k, ix, fe;
        bit ph, hide;
        e.t = tt; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (tt >= 4) begin
            k  = tt / 4;
            ix = (k - 1) % 4;
            fe = 4 * (k - ix);
            ph = ((tt / 32) % 2) == 1;
            e.dp = (ix == 2) ? 1'b0 : 1'b1;
            hide = ha[tt] && ph && ((hs[tt] == 2'b01 && ix >= 2) ||
                                    (hs[tt] == 2'b10 && ix <= 1));
            if (!hide) begin
                e.an  = 4'hF ^ (4'b0001 << ix);
                e.seg = lut[hd[ix][fe]];
            end
        end
        return e;
    endfunction

    // Record inputs for the coming edge, take it, queue the expectation.
    task automatic step();
        int n;
        n = t + 1;
        if (n >= 1024) begin
            $display("FAIL history overflow t=%0d limit=1023", n);
            fails++;
            $fatal(1, "history overflow");
        end
        hd[0][n] = c0; hd[1][n] = {1'b0, c1};
        hd[2][n] = c2; hd[3][n] = {1'b0, c3};
        ha[n] = adj; hs[n] = sel;
        @(posedge clk);
        t = n;
        #1 q.push_back(model(t));
    endtask

    task automatic chk_reset(input string name);
        tests++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            fails++;
            $display("FAIL %s an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1",
                     name, an, seg, dp);
        end
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        #20 rst_n = 1'b1;
        t = 0;
    endtask

    task automatic rand_inputs();
        if ($urandom_range(7) == 0) c0 = 4'($urandom);
        if ($urandom_range(7) == 0) c1 = 3'($urandom);
        if ($urandom_range(7) == 0) c2 = 4'($urandom);
        if ($urandom_range(7) == 0) c3 = 3'($urandom);
    endtask

    // Monitor: compare each queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                fails++;
                $display("FAIL out t=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                         e.t, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset("power_on_reset");
        repeat (2) @(posedge clk);
        #1 chk_reset("held_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        t = 0;

        // Free-run 3,4,5,9 with a mid-frame change of the seconds ones digit.
        c3 = 3'd3; c2 = 4'd4; c1 = 3'd5; c0 = 4'd9;
        adj = 1'b0; sel = 2'b00;
        repeat (24) begin
            step();
            if (t == 8) c0 = 4'd2;
        end

        // Reset dropped mid-scan, then a short run and another mid-scan reset.
        do_reset();
        repeat (10) step();
        do_reset();

        // Adjust mode: each select code across both blink phases; one
        // window also carries an out-of-range minutes ones digit.
        c3 = 3'd1; c2 = 4'd7; c1 = 3'd2; c0 = 4'd6;
        adj = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : (s == 2) ? 2'b00 : 2'b11;
            if (s == 2) c2 = 4'hC;
            if (s == 3) c2 = 4'd8;
            repeat (70) step();
        end

        // Random digits (including out-of-range codes) and adjust controls.
        repeat (400) begin
            rand_inputs();
            if ((t % 16) == 0) begin
                adj = 1'($urandom);
                sel = 2'($urandom);
            end
            step();
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
